// File: rtl/result_c_write_sequencer_if.sv
// result_c_write_sequencer_if: result beat input, result-C memory write port and pass status.
// master drives start/in_valid/in_data/mem_ready; slave (the sequencer) drives the rest.
interface result_c_write_sequencer_if #(
  parameter int LANES  = 32,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 10
);
  logic                    start;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    mem_ready;
  logic                    wr_en;
  logic [LANES*ADDR_W-1:0] wr_addr;
  logic [LANES*DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]        beat_count;
  logic                    done_n;
  modport master (
    output start, in_valid, in_data, mem_ready,
    input  in_ready, wr_en, wr_addr, wr_data, beat_count, done_n
  );
  modport slave (
    input  start, in_valid, in_data, mem_ready,
    output in_ready, wr_en, wr_addr, wr_data, beat_count, done_n
  );
endinterface

// File: rtl/result_c_write_sequencer.sv
// result_c_write_sequencer: writes LANES result words per beat to result-C memory at b*LANES+i.
// Ports: clk (state on falling edge), reset (async, active-low), bus (slave modport):
//   start/in_valid/in_ready/in_data in, mem_ready/wr_en/wr_addr/wr_data out, beat_count, done_n.
module result_c_write_sequencer #(
  parameter int LANES  = 32,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int BEATS  = 512,
  parameter int CNT_W  = 10
) (
  input logic                      clk,
  input logic                      reset,
  result_c_write_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]        beat_count_q, beat_count_d;
  logic                    wr_en_q, wr_en_d;
  logic                    done_n_q, done_n_d;
  logic [LANES*ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [LANES*DATA_W-1:0] wr_data_q, wr_data_d;
  logic [LANES*ADDR_W-1:0] base_addr, step_addr;
  logic                    in_ready, accept, commit, last_commit;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      base_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(i);
      step_addr[i*ADDR_W +: ADDR_W] = wr_addr_q[i*ADDR_W +: ADDR_W] + ADDR_W'(LANES);
    end
  end

  // Single output stage: a new beat may enter while the held write commits.
  assign in_ready    = state_q == RUN && acc_cnt_q < CNT_W'(BEATS) && (!wr_en_q || bus.mem_ready);
  assign accept      = bus.in_valid && in_ready;
  assign commit      = wr_en_q && bus.mem_ready;
  assign last_commit = commit && beat_count_q == CNT_W'(BEATS - 1);

  always_comb begin
    state_d      = state_q;
    acc_cnt_d    = acc_cnt_q;
    beat_count_d = beat_count_q;
    wr_en_d      = wr_en_q;
    done_n_d     = done_n_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (bus.start && state_q != RUN) begin
      state_d      = RUN;
      acc_cnt_d    = '0;
      beat_count_d = '0;
      wr_en_d      = 1'b0;
      done_n_d     = 1'b1;
      wr_addr_d    = base_addr;
    end else if (state_q == RUN) begin
      beat_count_d = commit && beat_count_q != CNT_W'(BEATS) ? beat_count_q + 1'b1 : beat_count_q;
      wr_en_d      = accept || (wr_en_q && !bus.mem_ready);
      if (accept) begin
        wr_data_d = bus.in_data;
        acc_cnt_d = acc_cnt_q + 1'b1;
        // The first beat of a pass keeps the base addresses; later beats stride by LANES.
        wr_addr_d = acc_cnt_q == '0 ? base_addr : step_addr;
      end
      if (last_commit) begin
        state_d  = DONE;
        done_n_d = 1'b0;
        wr_en_d  = 1'b0;
      end
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      acc_cnt_q    <= '0;
      beat_count_q <= '0;
      wr_en_q      <= 1'b0;
      done_n_q     <= 1'b1;
      wr_addr_q    <= base_addr;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      beat_count_q <= beat_count_d;
      wr_en_q      <= wr_en_d;
      done_n_q     <= done_n_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.beat_count = beat_count_q;
  assign bus.done_n     = done_n_q;
endmodule

// File: tb/tb_result_c_write_sequencer.sv
// tb_result_c_write_sequencer: random-stimulus bench against a beat-level reference model.
module tb_result_c_write_sequencer;
  localparam int LANES = 32, ADDR_W = 14, DATA_W = 32, BEATS = 512, CNT_W = 10;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  result_c_write_sequencer_if #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  result_c_write_sequencer #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .CNT_W(CNT_W))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  bit running, done_m, pending;
  int na, nc, idx;
  logic [LANES*DATA_W-1:0] exp_data;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LANES*ADDR_W-1:0] addr_of(input int b);
    logic [LANES*ADDR_W-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*ADDR_W +: ADDR_W] = ADDR_W'(b * LANES + l);
    return r;
  endfunction

  task automatic model_reset();
    running = 0; done_m = 0; pending = 0; na = 0; nc = 0; idx = 0; exp_data = '0;
  endtask

  task automatic check_outputs();
    check("in_ready", 512'(bus.in_ready), 512'(running && na < BEATS && (!pending || bus.mem_ready)));
    check("wr_en", 512'(bus.wr_en), 512'(pending));
    check("wr_addr", 512'(bus.wr_addr), 512'(addr_of(idx)));
    check("data_lo", bus.wr_data[511:0], exp_data[511:0]);
    check("data_hi", bus.wr_data[1023:512], exp_data[1023:512]);
    check("beat_count", 512'(bus.beat_count), 512'(nc));
    check("done_n", 512'(bus.done_n), 512'(!done_m));
  endtask

  // One falling edge worth of the pass rules, in beats rather than registers.
  task automatic model_edge();
    bit acc, com;
    acc = running && bus.in_valid && na < BEATS && (!pending || bus.mem_ready);
    com = pending && bus.mem_ready;
    if (bus.start && !running) begin
      running = 1; done_m = 0; na = 0; nc = 0; pending = 0; idx = 0;
    end else if (running) begin
      if (com) nc++;
      if (acc) begin
        pending = 1; idx = na; exp_data = bus.in_data; na++;
      end else if (com) pending = 0;
      if (com && nc == BEATS) begin
        running = 0; done_m = 1; pending = 0;
      end
    end
  endtask

  task automatic set_in(input bit v, input bit m, input bit s);
    bus.in_valid = v;
    bus.mem_ready = m;
    bus.start = s;
    for (int w = 0; w < LANES; w++) bus.in_data[w*DATA_W +: DATA_W] = $urandom();
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic run_pass(input int mode);
    int n = 0;
    int stall = 0;
    bit started = 0;
    bit v, m, s;
    while (!done_m && n < 3000) begin
      v = 1; m = 1; s = 0;
      if (mode == 1) begin
        if (pending && idx == 5 && stall < 3) begin
          m = 0;
          stall++;
          check("stall_lane0", 512'(bus.wr_addr[ADDR_W-1:0]), 512'(5 * LANES));
        end
        if (nc == 100 && !started) begin
          s = 1;
          started = 1;
        end
      end else if (mode == 2) begin
        v = 1'($urandom_range(0, 1));
        m = $urandom_range(0, 3) != 0;
      end
      set_in(v, m, s);
      cycle();
      n++;
    end
    check("pass_done_n", 512'(bus.done_n), 512'(0));
    check("pass_beats", 512'(bus.beat_count), 512'(BEATS));
    check("last_lane", 512'(bus.wr_addr[(LANES-1)*ADDR_W +: ADDR_W]), 512'(LANES * BEATS - 1));
  endtask

  initial begin
    int n;
    bus.start = 0; bus.in_valid = 0; bus.mem_ready = 0; bus.in_data = '0;
    model_reset();
    @(negedge clk);
    #1;
    cycle();
    reset = 1'b1;
    repeat (4) begin set_in(1, 1, 0); cycle(); end
    set_in(1, 1, 1); cycle();
    run_pass(0);
    repeat (4) begin set_in(1, 1, 0); cycle(); end
    set_in(0, 1, 1); cycle();
    run_pass(1);
    repeat (3) begin set_in(1, 0, 0); cycle(); end
    set_in(1, 1, 1); cycle();
    run_pass(2);
    set_in(1, 1, 1); cycle();
    n = 0;
    while (!(nc >= 300 && pending) && n < 2000) begin
      set_in(1, 1, 0);
      cycle();
      n++;
    end
    check("pre_reset_wr_en", 512'(bus.wr_en), 512'(1));
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (3) begin set_in(1, 1, 0); cycle(); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_c_write_sequencer.md
Name: result_c_write_sequencer

Overview:
- Write-side counterpart of the A-operand read address sequencer.
- Accepts LANES parallel result words per beat from the multiplier array and emits one registered write per beat to the banked result-C memory.
- Lane i of beat b is written to address b*LANES + i, the same stride-LANES interleave the read side uses.
- Counts beats, applies backpressure from the memory, and asserts an active-low done flag when BEATS beats have been committed.

Parameters:
- LANES, 32, parallel lanes per beat.
- ADDR_W, 14, address width per lane; LANES*BEATS must equal 2^ADDR_W.
- DATA_W, 32, result word width.
- BEATS, 512, beats per matrix pass.
- CNT_W, 10, beat counter width; must hold BEATS.

Ports:
- clk, input, 1, clock; all state updates on the falling edge.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, single-cycle pulse that begins a pass; honoured only in IDLE or DONE.
- in_valid, input, 1, a result beat is present on in_data.
- in_ready, output, 1, the block accepts a beat this cycle.
- in_data, input, LANES*DATA_W, lane i occupies bits [i*DATA_W +: DATA_W].
- mem_ready, input, 1, the memory accepts the presented write this cycle.
- wr_en, output, 1, a write is presented on wr_addr/wr_data.
- wr_addr, output, LANES*ADDR_W, lane i address at [i*ADDR_W +: ADDR_W].
- wr_data, output, LANES*DATA_W, registered copy of the accepted in_data.
- beat_count, output, CNT_W, number of beats committed to memory.
- done_n, output, 1, low when the pass is complete.

Behaviour:
- Reset (async, active-low):
  - state = IDLE; beat_count = 0; accept counter = 0; wr_en = 0.
  - Lane i of wr_addr = i; wr_data = 0; done_n = 1; in_ready = 0.
  - Reset asserted mid-pass abandons the pass immediately; no write completes after reset asserts.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN -> DONE when the final write commits (wr_en && mem_ready with beat_count == BEATS-1).
  - DONE -> RUN on start.
  - start in RUN is ignored.
- Entry to RUN:
  - accept counter = 0; beat_count = 0; done_n = 1; lane i address = i; wr_en = 0.
- in_ready (combinational):
  - Equals (state == RUN) && (accept counter < BEATS) && (!wr_en || mem_ready).
  - The output register is a single stage; a beat may be accepted in the same cycle as the current write commits.
- Accept (in_valid && in_ready):
  - On that falling edge: wr_data <= in_data; wr_en <= 1; accept counter increments.
  - wr_addr for that beat = accept index*LANES + i. All lane addresses advance together by LANES per accepted beat, after the first.
  - The first beat of a pass uses the base addresses 0..LANES-1.
  - One cycle latency from accept to wr_en.
- Commit (wr_en && mem_ready):
  - beat_count increments.
  - If no new accept occurs in the same cycle, wr_en <= 0.
- Stall (wr_en && !mem_ready):
  - wr_en, wr_addr and wr_data hold unchanged.
  - in_ready = 0.
- Completion:
  - After BEATS accepts, in_ready stays 0.
  - On the final commit: done_n <= 0 and wr_en <= 0.
  - Last lane address written = LANES*BEATS-1 (16383 with defaults); addresses never wrap within a pass.
  - done_n stays low in DONE until the next start or reset.
- Width rules:
  - Address adds are modulo 2^ADDR_W.
  - beat_count saturates at BEATS; it never exceeds BEATS.
- Ignored inputs:
  - in_valid in IDLE or DONE has no effect.
  - in_data is not sampled unless in_ready is high.

Test Plan:
- Reset then start; in_valid and mem_ready held high -> wr_en first asserts one cycle after the first accept with lane0 = 0, lane31 = 31; second write lane0 = 32; 512 writes occur; last lane31 = 16383; done_n falls on the edge of the 512th commit; beat_count = 512.
- mem_ready low for 3 cycles during beat 5 -> wr_addr lane0 holds 160 and wr_data holds for 3 cycles; in_ready = 0; no beat is lost or duplicated; total of 512 commits.
- in_valid toggled 1/0 randomly with mem_ready high -> addresses remain strictly sequential in steps of 32; final done_n = 0; beat_count = 512.
- start pulsed mid-pass at beat 100 -> ignored; the pass completes normally. A second start in DONE -> done_n returns to 1, lane0 address restarts at 0, beat_count = 0.
- reset asserted asynchronously at beat 300 while wr_en = 1 -> wr_en = 0, done_n = 1, state IDLE and beat_count = 0 immediately, without waiting for a clock edge.
- in_valid held high in IDLE and DONE -> in_ready = 0 and wr_en stays 0.
